// File: rtl/fifo_sync_null_param.sv
// fifo_sync_null_param
// Parametrised single-clock FIFO with NULL-token handling.
//   - True occupancy count (ADDR_W+1 bits), so full and empty are never ambiguous.
//   - DROP_NULL: NULL_WORD writes are discarded while almost_full and counted in drop_cnt.
//   - RD_HOLD_AE: reads are refused while almost_empty (legacy behaviour).
//   - Sticky wr_err/rd_err flags and a synchronous flush (clr).
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   clr                 synchronous flush of pointers, count, errors and drop_cnt
//   wr_en, wr_data      write request and data
//   rd_en               read request
//   rd_data, rd_valid   registered read data (NULL_WORD on a refused read), real-word strobe
//   count               stored words, 0..DEPTH
//   full, empty, almost_full, almost_empty   decodes of count
//   drop_cnt            saturating count of discarded NULL words
//   wr_err, rd_err      sticky overflow / refused-read flags
module fifo_sync_null_param #(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      ADDR_W     = 6,
    parameter int unsigned      AF_LEVEL   = 48,
    parameter int unsigned      AE_LEVEL   = 16,
    parameter logic [WIDTH-1:0] NULL_WORD  = '0,
    parameter bit               DROP_NULL  = 1'b1,
    parameter bit               RD_HOLD_AE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [15:0]       drop_cnt,
    output logic              wr_err,
    output logic              rd_err
);

    localparam int unsigned     DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AF_CNT    = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_CNT    = AE_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] CNT_ONE   = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic drop;
    logic wr_acc;
    logic rd_block;
    logic rd_acc;

    // Flags are pure decodes of the registered count.
    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count < AE_CNT);

    // A NULL arriving while full is an overflow, not a drop, hence the !full term.
    assign drop     = wr_en & DROP_NULL & almost_full & ~full & (wr_data == NULL_WORD);
    assign wr_acc   = wr_en & ~full & ~drop & ~clr;
    assign rd_block = empty | (RD_HOLD_AE & almost_empty);
    assign rd_acc   = rd_en & ~rd_block & ~clr;

    // Storage is not reset; only words covered by count are ever read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= NULL_WORD;
            rd_valid <= 1'b0;
            drop_cnt <= '0;
            wr_err   <= 1'b0;
            rd_err   <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= NULL_WORD;
            rd_valid <= 1'b0;
            drop_cnt <= '0;
            wr_err   <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            if (rd_acc) begin
                rd_data  <= mem[rd_ptr];
                rd_valid <= 1'b1;
                rd_ptr   <= rd_ptr + PTR_ONE;
            end else if (rd_en) begin
                rd_data  <= NULL_WORD;
                rd_valid <= 1'b0;
                rd_err   <= 1'b1;
            end else begin
                rd_valid <= 1'b0;
            end

            if (wr_en && full) begin
                wr_err <= 1'b1;
            end

            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end

            // Read and write are decided independently against the same
            // registered count, so there is no fall-through on empty or full.
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_sync_null_param.sv
// Bench for fifo_sync_null_param. Three instances share the stimulus:
//   a: defaults (DROP_NULL=1, RD_HOLD_AE=0) - full queue model and read scoreboard
//   b: DROP_NULL=0
//   c: RD_HOLD_AE=1
module tb_fifo_sync_null_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic [7:0]  rd_data_a, rd_data_b, rd_data_c;
    logic        rd_valid_a, rd_valid_b, rd_valid_c;
    logic [6:0]  count_a, count_b, count_c;
    logic        full_a, full_b, full_c;
    logic        empty_a, empty_b, empty_c;
    logic        af_a, af_b, af_c;
    logic        ae_a, ae_b, ae_c;
    logic [15:0] drop_a, drop_b, drop_c;
    logic        wr_err_a, wr_err_b, wr_err_c;
    logic        rd_err_a, rd_err_b, rd_err_c;

    fifo_sync_null_param dut_a (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .count(count_a), .full(full_a),
        .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a), .drop_cnt(drop_a),
        .wr_err(wr_err_a), .rd_err(rd_err_a)
    );

    fifo_sync_null_param #(.DROP_NULL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .count(count_b), .full(full_b),
        .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b), .drop_cnt(drop_b),
        .wr_err(wr_err_b), .rd_err(rd_err_b)
    );

    fifo_sync_null_param #(.RD_HOLD_AE(1'b1)) dut_c (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data_c), .rd_valid(rd_valid_c), .count(count_c), .full(full_c),
        .empty(empty_c), .almost_full(af_c), .almost_empty(ae_c), .drop_cnt(drop_c),
        .wr_err(wr_err_c), .rd_err(rd_err_c)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];     // model contents of instance a
    logic [7:0] exp_q[$];  // expected read words of instance a, in order
    logic [7:0] exp_word;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One clock of stimulus; the model of instance a decides acceptance
    // from its own occupancy before the edge.
    task automatic step(input bit we, input logic [7:0] wd, input bit re);
        bit mfull, maf, mempty, mdrop, wacc, racc;
        mfull  = (mq.size() == 64);
        maf    = (mq.size() >= 48);
        mempty = (mq.size() == 0);
        mdrop  = we && maf && !mfull && (wd == 8'h00);
        wacc   = we && !mfull && !mdrop;
        racc   = re && !mempty;
        if (racc) exp_q.push_back(mq.pop_front());
        if (wacc) mq.push_back(wd);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("count_a", int'(count_a), mq.size());
        if (re && !racc) begin
            chk("refused_valid_a", int'(rd_valid_a), 0);
            chk("refused_data_a", int'(rd_data_a), 0);
            chk("refused_rd_err_a", int'(rd_err_a), 1);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
        mq.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every real word from instance a must be the next expected one.
    always @(negedge clk) begin
        if (rd_valid_a) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected_a: got 0x%0h expected no valid word", rd_data_a);
            end else begin
                exp_word = exp_q.pop_front();
                chk("rd_word_a", int'(rd_data_a), int'(exp_word));
            end
        end
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_count", int'(count_a), 0);
        chk("rst_empty", int'(empty_a), 1);
        chk("rst_ae", int'(ae_a), 1);
        chk("rst_full", int'(full_a), 0);
        chk("rst_af", int'(af_a), 0);
        chk("rst_valid", int'(rd_valid_a), 0);
        chk("rst_data", int'(rd_data_a), 0);
        chk("rst_drop", int'(drop_a), 0);
        chk("rst_errs", int'({wr_err_a, rd_err_a}), 0);

        // Fill to full, overflow, drain, then reads on empty
        for (int i = 1; i <= 64; i++) step(1'b1, 8'(i), 1'b0);
        chk("fill_count", int'(count_a), 64);
        chk("fill_full", int'(full_a), 1);
        chk("fill_af", int'(af_a), 1);
        chk("fill_wr_err_pre", int'(wr_err_a), 0);
        step(1'b1, 8'hAA, 1'b0);
        chk("ovf_count", int'(count_a), 64);
        chk("ovf_wr_err", int'(wr_err_a), 1);
        chk("ovf_full_b", int'(full_b), 1);
        for (int i = 0; i < 64; i++) step(1'b0, 8'h00, 1'b1);
        chk("drain_empty", int'(empty_a), 1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h33, 1'b1);
        chk("wr_on_empty_count", int'(count_a), 1);
        step(1'b0, 8'h00, 1'b1);
        chk("read_33_valid", int'(rd_valid_a), 1);
        chk("read_33_data", int'(rd_data_a), 8'h33);

        // NULL dropping near full (a drops, b stores)
        do_reset();
        for (int i = 1; i <= 48; i++) step(1'b1, 8'(i), 1'b0);
        chk("af_at_48", int'(af_a), 1);
        step(1'b1, 8'h00, 1'b0);
        chk("null_count_a", int'(count_a), 48);
        chk("null_drop_a", int'(drop_a), 1);
        chk("null_count_b", int'(count_b), 49);
        chk("null_drop_b", int'(drop_b), 0);
        step(1'b1, 8'h5A, 1'b0);
        chk("5a_count_a", int'(count_a), 49);
        chk("5a_count_b", int'(count_b), 50);

        // Read hold while almost empty (c)
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h11 + i), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("hold_valid_c", int'(rd_valid_c), 0);
        chk("hold_data_c", int'(rd_data_c), 0);
        chk("hold_count_c", int'(count_c), 10);
        chk("hold_rd_err_c", int'(rd_err_c), 1);
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h1B + i), 1'b0);
        chk("hold_fill_c", int'(count_c), 16);
        step(1'b0, 8'h00, 1'b1);
        chk("release_valid_c", int'(rd_valid_c), 1);
        chk("release_data_c", int'(rd_data_c), 8'h11);
        chk("release_count_c", int'(count_c), 15);

        // Steady state with pointer wrap
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 8'(i + 1), 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, 8'(i + 33), 1'b1);
        chk("steady_count", int'(count_a), 32);
        for (int i = 0; i < 32; i++) step(1'b0, 8'h00, 1'b1);
        chk("steady_drained", int'(empty_a), 1);

        // Asynchronous reset mid-burst
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i + 1), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(i + 50), 1'b1);
        rst = 1'b1;
        mq.delete();
        exp_q.delete();
        #1;
        chk("midrst_count", int'(count_a), 0);
        chk("midrst_valid", int'(rd_valid_a), 0);
        chk("midrst_errs", int'({wr_err_a, rd_err_a}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        chk("postrst_valid", int'(rd_valid_a), 0);

        // Synchronous flush with a concurrent write request
        step(1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 48; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'h00, 1'b0);
        chk("preclr_drop", int'(drop_a), 1);
        clr     = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h77;
        rd_en   = 1'b1;
        @(posedge clk);
        #1;
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        mq.delete();
        chk("clr_count", int'(count_a), 0);
        chk("clr_drop", int'(drop_a), 0);
        chk("clr_rd_err", int'(rd_err_a), 0);
        chk("clr_valid", int'(rd_valid_a), 0);
        chk("clr_empty", int'(empty_a), 1);

        @(negedge clk);
        chk("leftover_expected", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
